tcp_tx_datap: RTL

- Transmit-side datapath and control for the slow TCP engine; the counterpart of the RX datapath.
- Accepts a per-flow send command from the scheduler and reads the flow's TX state, RX state, TX head/tail pointers and four-tuple.
- Computes sequence number, ACK number, window and payload length, then emits one TCP header plus a payload-buffer descriptor to the packet assembler.
- Writes back the advanced sequence number and issues a scheduler pend-bit update.

---
 rtl/tcp_tx_datap.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tcp_tx_datap.sv
// tcp_tx_datap: TCP transmit datapath; define TCP_TX_DATAP_ZERO_WIN_PROBE_EN to send 1-byte zero-window probes
module tcp_tx_datap #(
  parameter int FLOWID_W = 6,
  parameter int TX_PAYLOAD_PTR_W = 14,
  parameter int MSS = 1460,
  parameter int WIN_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sched_tx_req_val,
  input  logic [FLOWID_W-1:0]           sched_tx_req_flowid,
  input  logic [1:0]                    sched_tx_req_cmd,
  output logic                          sched_tx_req_rdy,
  output logic [FLOWID_W-1:0]           flow_rd_req_addr,
  output logic                          flow_rd_req_val,
  input  logic [31:0]                   tx_state_rd_resp_our_seq,
  input  logic [31:0]                   rx_state_rd_resp_ack_num,
  input  logic [31:0]                   rx_state_rd_resp_their_ack,
  input  logic [WIN_W-1:0]              rx_state_rd_resp_their_win,
  input  logic [TX_PAYLOAD_PTR_W:0]     rx_state_rd_resp_our_win,
  input  logic [TX_PAYLOAD_PTR_W:0]     tx_head_ptr_rd_resp,
  input  logic [TX_PAYLOAD_PTR_W:0]     tx_tail_ptr_rd_resp,
  input  logic [95:0]                   tuple_rd_resp,
  output logic                          tx_state_wr_req_val,
  output logic [FLOWID_W-1:0]           tx_state_wr_req_addr,
  output logic [31:0]                   tx_state_wr_req_seq,
  output logic                          tx_pkt_val,
  input  logic                          tx_pkt_rdy,
  output logic [159:0]                  tx_pkt_hdr,
  output logic [31:0]                   tx_pkt_src_ip,
  output logic [31:0]                   tx_pkt_dst_ip,
  output logic [FLOWID_W-1:0]           tx_pkt_flowid,
  output logic [TX_PAYLOAD_PTR_W-1:0]   tx_pkt_payload_addr,
  output logic [15:0]                   tx_pkt_payload_len,
  output logic                          tx_sched_update_val,
  output logic [FLOWID_W+37:0]          tx_sched_update_cmd
);
  localparam int P = TX_PAYLOAD_PTR_W;
  localparam logic [1:0] NOP = 2'd0, SET = 2'd1, CLR = 2'd2;
  localparam logic [31:0] WIN_MAX = (32'd1 << WIN_W) - 32'd1;
  typedef enum logic [2:0] {IDLE, READ, CALC, SEND, WB} state_t;
  state_t state, state_nx;
  logic [FLOWID_W-1:0] flowid_q;
  logic [1:0] cmd_q;
  logic [31:0] our_seq_q, ack_num_q, their_ack_q, avail_q;
  logic [WIN_W-1:0] their_win_q, win_fld;
  logic [P:0] our_win_q, head_q, tail_q, avail_d, avail_r;
  logic [95:0] tuple_q;
  logic sent_q, adv_q, is_data, is_rt, probe_c, sent_c, adv_c;
  logic [31:0] inflight, win_rem, avail_c, seq_c;
  logic [15:0] len_c;
  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] m;
    m = a < b ? a : b;
    return m < c ? m : c;
  endfunction
  // segment sizing: sequence, payload length and window from the registered flow state
  always_comb begin
    is_data = cmd_q == 2'd1;
    is_rt = cmd_q == 2'd2;
    inflight = our_seq_q - ack_num_q;
    win_rem = inflight >= 32'(their_win_q) ? 32'd0 : 32'(their_win_q) - inflight;
    avail_d = tail_q - our_seq_q[P:0];
    avail_r = tail_q - head_q;
    avail_c = is_rt ? 32'(avail_r) : 32'(avail_d);
`ifdef TCP_TX_DATAP_ZERO_WIN_PROBE_EN
    probe_c = is_data && win_rem == 32'd0 && avail_c != 32'd0;
`else
    probe_c = 1'b0;
`endif
    len_c = probe_c ? 16'd1 : is_data ? 16'(min3(avail_c, win_rem, 32'(MSS))) :
            is_rt ? 16'(min3(avail_c, 32'(their_win_q), 32'(MSS))) : 16'd0;
    seq_c = is_rt ? ack_num_q : our_seq_q;
    win_fld = 32'(our_win_q) > WIN_MAX ? {WIN_W{1'b1}} : WIN_W'(our_win_q);
    sent_c = !(is_data && len_c == 16'd0);
    adv_c = is_data && len_c != 16'd0 && !probe_c;
  end
  // next-state: DATA with nothing sendable skips straight to write-back
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = sched_tx_req_val ? READ : IDLE;
      READ: state_nx = CALC;
      CALC: state_nx = sent_c ? SEND : WB;
      SEND: state_nx = tx_pkt_rdy ? WB : SEND;
      WB: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register; reset drops any in-flight command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // command latch, flow-state capture and packet output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flowid_q <= '0;
      cmd_q <= '0;
      our_seq_q <= '0;
      ack_num_q <= '0;
      their_ack_q <= '0;
      their_win_q <= '0;
      our_win_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      tuple_q <= '0;
      avail_q <= '0;
      sent_q <= 1'b0;
      adv_q <= 1'b0;
      tx_pkt_hdr <= '0;
      tx_pkt_src_ip <= '0;
      tx_pkt_dst_ip <= '0;
      tx_pkt_flowid <= '0;
      tx_pkt_payload_addr <= '0;
      tx_pkt_payload_len <= '0;
    end else begin
      if (state == IDLE && sched_tx_req_val) begin
        flowid_q <= sched_tx_req_flowid;
        cmd_q <= sched_tx_req_cmd;
      end
      if (state == READ) begin
        our_seq_q <= tx_state_rd_resp_our_seq;
        ack_num_q <= rx_state_rd_resp_ack_num;
        their_ack_q <= rx_state_rd_resp_their_ack;
        their_win_q <= rx_state_rd_resp_their_win;
        our_win_q <= rx_state_rd_resp_our_win;
        head_q <= tx_head_ptr_rd_resp;
        tail_q <= tx_tail_ptr_rd_resp;
        tuple_q <= tuple_rd_resp;
      end
      if (state == CALC) begin
        avail_q <= avail_c;
        sent_q <= sent_c;
        adv_q <= adv_c;
        tx_pkt_hdr <= {tuple_q[31:16], tuple_q[15:0], seq_c, their_ack_q, 4'd5, 6'd0,
                       2'b01, len_c != 16'd0, 3'b000, 16'(win_fld), 16'd0, 16'd0};
        tx_pkt_src_ip <= tuple_q[95:64];
        tx_pkt_dst_ip <= tuple_q[63:32];
        tx_pkt_flowid <= flowid_q;
        tx_pkt_payload_addr <= seq_c[P-1:0];
        tx_pkt_payload_len <= len_c;
      end
    end
  end
  assign sched_tx_req_rdy = state == IDLE;
  assign flow_rd_req_val = state == IDLE && sched_tx_req_val;
  assign flow_rd_req_addr = state == IDLE ? sched_tx_req_flowid : flowid_q;
  assign tx_pkt_val = state == SEND;
  assign tx_state_wr_req_val = state == WB && adv_q;
  assign tx_state_wr_req_addr = flowid_q;
  assign tx_state_wr_req_seq = our_seq_q + 32'(tx_pkt_payload_len);
  assign tx_sched_update_val = state == WB;
  assign tx_sched_update_cmd = {flowid_q, sent_q ? CLR : NOP,
                                avail_q == 32'(tx_pkt_payload_len) ? CLR : NOP,
                                tx_pkt_payload_len != 16'd0 ? SET : NOP, 32'd0};
endmodule
